// File: rtl/gpio_port.sv
// Purpose: N-channel GPIO port: bus-driven output register with blink, debounced inputs, sticky edge events, irq.
// Latency: output operations show on pins_out one cycle after the strobe edge; an input change is accepted DEBOUNCE+2 edges after it is first sampled.
// Backpressure: none; every strobe is accepted in the cycle it is asserted.
//
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   bus, a_out                          CPU bus and A register; only bits [N-1:0] are used
//   out_set/out_clear/out_clr_all/      output register operations; priority
//   out_mwo/out_toggle                    clr_all > mwo > clear > set > toggle
//   blink_load, irq_mask_load, ev_clr   load blink mask, load irq mask, write-1-to-clear events
//   pins_in                             raw asynchronous input pins
//   pins_out, in_state, events, irq     driven pins, debounced levels, sticky change flags, interrupt
module gpio_port #(
    parameter int WIDTH     = 16,
    parameter int N         = 10,
    parameter int DEBOUNCE  = 4,
    parameter int BLINK_DIV = 4,
    parameter int IN_INVERT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus,
    input  logic [WIDTH-1:0] a_out,
    input  logic             out_set,
    input  logic             out_clear,
    input  logic             out_clr_all,
    input  logic             out_mwo,
    input  logic             out_toggle,
    input  logic             blink_load,
    input  logic             irq_mask_load,
    input  logic             ev_clr,
    input  logic [N-1:0]     pins_in,
    output logic [N-1:0]     pins_out,
    output logic [N-1:0]     in_state,
    output logic [N-1:0]     events,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [N-1:0] INV_MASK = (IN_INVERT != 0) ? {N{1'b1}} : {N{1'b0}};
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);

    logic [N-1:0] bus_n;
    logic [N-1:0] mask_n;

    assign bus_n  = bus[N-1:0];
    assign mask_n = a_out[N-1:0];

    // Upper bus/A bits are architecturally ignored.
    if (N < WIDTH) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^{bus[WIDTH-1:N], a_out[WIDTH-1:N]};
    end

    // Output register and blink state
    logic [N-1:0]  out_q, out_d;
    logic [N-1:0]  blink_q, blink_d;
    logic [N-1:0]  irqm_q, irqm_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          phase_q, phase_d;

    always_comb begin
        out_d = out_q;
        if (out_clr_all) begin
            out_d = '0;
        end else if (out_mwo) begin
            out_d = (out_q & ~mask_n) | (bus_n & mask_n);
        end else if (out_clear) begin
            out_d = out_q & ~bus_n;
        end else if (out_set) begin
            out_d = out_q | bus_n;
        end else if (out_toggle) begin
            out_d = out_q ^ bus_n;
        end

        blink_d = blink_load    ? bus_n : blink_q;
        irqm_d  = irq_mask_load ? bus_n : irqm_q;

        // Free-running prescaler; phase flips on the wrap edge.
        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end else begin
            presc_d = presc_q + 1'b1;
            phase_d = phase_q;
        end
    end

    // Input synchroniser, debounce and events
    logic [N-1:0]  s1_q, s2_q;
    logic [N-1:0]  state_q, state_d;
    logic [N-1:0]  ev_q, ev_d;
    logic [N-1:0]  ev_set;
    logic [N-1:0]  v;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    always_comb begin
        v       = s2_q ^ INV_MASK;
        state_d = state_q;
        ev_set  = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (v[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                state_d[i] = v[i];
                cnt_d[i]   = '0;
                ev_set[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // A new event on the same edge as its clear must survive.
        ev_d = (ev_q & ~({N{ev_clr}} & bus_n)) | ev_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            blink_q <= '0;
            irqm_q  <= '0;
            presc_q <= '0;
            phase_q <= 1'b0;
            s1_q    <= INV_MASK;
            s2_q    <= INV_MASK;
            state_q <= '0;
            ev_q    <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q   <= out_d;
            blink_q <= blink_d;
            irqm_q  <= irqm_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            s1_q    <= pins_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            ev_q    <= ev_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pins_out = out_q ^ (blink_q & {N{phase_q}});
    assign in_state = state_q;
    assign events   = ev_q;
    assign irq      = |(ev_q & irqm_q);

endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Parametrised successor to the single-register LED output block of the MEH16 CPU.
- Provides N output channels with the existing bus-driven set/clear/clear-all/masked-write operations, plus new toggle and per-channel blink operations.
- Adds an N-channel input side: synchroniser, per-channel debounce, and sticky edge-event latches with an interrupt output.
- Sits on the CPU bus next to reg_a; the controller drives its strobes.

Parameters:
- WIDTH, 16, bus and A-register width.
- N, 10, channel count; 1 <= N <= WIDTH.
- DEBOUNCE, 4, consecutive stable cycles required to accept an input change; >= 1.
- BLINK_DIV, 4, clk cycles per blink half-period; >= 1.
- IN_INVERT, 1, 1 = pins are active-low and are inverted after synchronisation.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- bus  in  WIDTH  CPU bus; only bits [N-1:0] are used.
- a_out  in  WIDTH  A register; bits [N-1:0] are the mask for masked write.
- out_set  in  1  out_reg |= bus.
- out_clear  in  1  out_reg &= ~bus.
- out_clr_all  in  1  out_reg = 0.
- out_mwo  in  1  out_reg = (out_reg & ~a_out) | (bus & a_out).
- out_toggle  in  1  out_reg ^= bus.
- blink_load  in  1  blink_mask = bus[N-1:0].
- irq_mask_load  in  1  irq_mask = bus[N-1:0].
- ev_clr  in  1  write-1-to-clear: events &= ~bus.
- pins_in  in  N  raw asynchronous input pins.
- pins_out  out  N  out_reg ^ (blink_mask & {N{phase}}).
- in_state  out  N  debounced, polarity-corrected input levels.
- events  out  N  sticky per-channel "state changed" flags.
- irq  out  1  |(events & irq_mask), combinational from registers.

Behaviour:
- Reset (async, while reset=0) clears out_reg, blink_mask, irq_mask, events, in_state, debounce counters, prescaler and phase to 0.
- Sync flops reset to the inactive pin level: 1 if IN_INVERT=1, else 0.
- Reset asserted mid-debounce or mid-blink discards all progress. The first edge after release behaves as from the reset state.

Output operations:
- At most one operation applies per cycle.
- Priority: out_clr_all > out_mwo > out_clear > out_set > out_toggle. Lower-priority strobes asserted in the same cycle are ignored.
- Results are visible on pins_out the cycle after the strobe edge (1-cycle latency).
- blink_load is independent of the output operations and may coincide with them.

Blink:
- The prescaler counts 0..BLINK_DIV-1. phase inverts on the edge where prescaler == BLINK_DIV-1, after which the prescaler wraps to 0.
- The prescaler free-runs and is not reset by blink_load.

Input path:
- Two-flop synchroniser per channel: s1 <= pins_in, s2 <= s1. Let v = s2 ^ IN_INVERT.
- Per-channel counter cnt, width clog2(DEBOUNCE+1):
  - If v == in_state: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: in_state <= v, cnt <= 0, event set.
  - Else: cnt++.
- A pin change held steady is accepted DEBOUNCE+2 edges after the first edge that samples it into s1.
- A glitch shorter than DEBOUNCE cycles (measured at v) causes no change and no event.

Events:
- A channel's event bit sets on the same edge in_state changes, for both rise and fall.
- If ev_clr clears a bit on the same edge that bit sets, set wins.
- ev_clr bits for channels without a pending event have no effect.
- irq updates combinationally from events and irq_mask. An irq_mask_load whose mask covers a pending event raises irq one cycle after the load edge.

Width rules:
- Bus bits [WIDTH-1:N] are ignored on all loads.
- Outputs are exactly N bits wide; no other outputs exist.

Test Plan:
- Reset, then out_set bus=0x005 -> pins_out=0x005 next cycle; then out_toggle bus=0x00F -> 0x00A; then out_clear bus=0x002 -> 0x008.
- out_reg=0x0F0, a_out=0x0FF, bus=0x30F, out_mwo with out_set also high -> pins_out=0x00F (mwo wins, bits above the mask held); then out_clr_all with out_mwo high -> 0x000.
- blink_load bus=0x001 with out_reg=0 -> pins_out[0] toggles every 4 cycles (period 8); bits [9:1] stay 0; blink_load 0 -> pins_out=out_reg.
- IN_INVERT=1, pins_in[3] driven 1->0 and held -> in_state[3]=1 and events=0x008 exactly 6 edges after the first sampling edge; a 3-cycle low glitch on pins_in[4] -> no state change, no event.
- irq_mask_load 0x008 with events[3]=1 -> irq=1; ev_clr bus=0x008 coincident with a new channel-3 transition acceptance -> events[3] stays 1; ev_clr next cycle -> events=0, irq=0.
- Assert reset low mid-debounce (cnt=2) and mid-blink -> all outputs 0 immediately (asynchronously); after release, a held pin change again needs the full 6 edges.
